// File: rtl/touch_adc_ctrl.sv
// SPI master for an AD7843-style resistive-touch ADC: debounces the pen, converts X then Y while
// the pen is down, and publishes coordinates. Define TOUCH_AVG_EN to publish 4-pair averages.
module touch_adc_ctrl #(
  parameter int CLK_DIV    = 50,
  parameter int DEBOUNCE   = 1000,
  parameter int GAP        = 20000,
  parameter int STROBE_LEN = 4
) (
  input  logic       sys_clk,
  input  logic       iRST,
  input  logic       adc_penirq_n,
  input  logic       adc_dout,
  output logic       adc_dclk,
  output logic       adc_din,
  output logic       adc_cs_n,
  output logic [7:0] x_out,
  output logic [9:0] y_out,
  output logic       new_coord,
  output logic       transmit_en,
  output logic       pen_strobe_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_CONV_X, S_CONV_Y, S_PUBLISH, S_GAP_WAIT, S_RELEASE
  } state_t;

  localparam logic [7:0] CMD_X   = 8'hD0;
  localparam logic [7:0] CMD_Y   = 8'h90;
  localparam int         CNT_MAX = (GAP > DEBOUNCE) ? GAP : DEBOUNCE;
  localparam int         CNT_W   = $clog2(CNT_MAX + 1);
  localparam int         DIV_W   = $clog2(CLK_DIV);
  localparam int         STB_W   = $clog2(STROBE_LEN + 1);
  // Half-period index within a frame: 0 = CS setup, 1..48 = DCLK, 49 = CS-high gap after X.
  localparam logic [5:0] PH_GAP     = 6'd49;
  localparam logic [5:0] PH_SMP_LO  = 6'd19;
  localparam logic [5:0] PH_SMP_HI  = 6'd41;

  state_t             state_q, state_d;
  logic               pen_meta_q, pen_sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         ph_q, ph_d;
  logic [7:0]         cmd_sh_q, cmd_sh_d;
  logic [11:0]        raw_q, raw_d;
  logic [11:0]        raw_x_q, raw_x_d;
  logic               cs_n_q, cs_n_d;
  logic               dclk_q, dclk_d;
  logic               din_q, din_d;
  logic [7:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic               new_coord_q, new_coord_d;
  logic               tx_en_q, tx_en_d;
  logic               strobe_n_q, strobe_n_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;

`ifdef TOUCH_AVG_EN
  logic [13:0]        sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [13:0]        sum_x_nx, sum_y_nx;
  logic [1:0]         avg_cnt_q, avg_cnt_d;
`endif

  logic               pen_down;
  logic               tick;
  logic [5:0]         ph_nx;
  logic               start_x, start_y;
  logic               pair_valid;

  function automatic logic is_valid(input logic [11:0] v);
    return (v != 12'h000) && (v != 12'hFFF);
  endfunction

  assign pen_down   = ~pen_sync_q;
  assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
  assign ph_nx      = ph_q + 6'd1;
  assign pair_valid = is_valid(raw_x_q) && is_valid(raw_q);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    ph_d        = ph_q;
    cmd_sh_d    = cmd_sh_q;
    raw_d       = raw_q;
    raw_x_d     = raw_x_q;
    cs_n_d      = cs_n_q;
    dclk_d      = dclk_q;
    din_d       = din_q;
    x_d         = x_q;
    y_d         = y_q;
    new_coord_d = 1'b0;
    tx_en_d     = tx_en_q;
    start_x     = 1'b0;
    start_y     = 1'b0;
`ifdef TOUCH_AVG_EN
    sum_x_d     = sum_x_q;
    sum_y_d     = sum_y_q;
    avg_cnt_d   = avg_cnt_q;
    sum_x_nx    = sum_x_q + {2'b00, raw_x_q};
    sum_y_nx    = sum_y_q + {2'b00, raw_q};
`endif

    // The strobe follows the new_coord cycle for STROBE_LEN cycles.
    strobe_n_d = (stb_cnt_q == '0);
    stb_cnt_d  = (stb_cnt_q != '0) ? stb_cnt_q - STB_W'(1) : stb_cnt_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef TOUCH_AVG_EN
        sum_x_d   = '0;
        sum_y_d   = '0;
        avg_cnt_d = '0;
`endif
        if (pen_down) state_d = S_DEBOUNCE;
      end

      S_DEBOUNCE: begin
        if (!pen_down) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          start_x = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CONV_X, S_CONV_Y: begin
        if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          ph_d  = ph_nx;
          if (ph_q == PH_GAP) begin
            start_y = 1'b1;
          end else if (ph_nx == PH_GAP) begin
            cs_n_d = 1'b1;
            dclk_d = 1'b0;
            din_d  = 1'b0;
            if (state_q == S_CONV_X) raw_x_d = raw_q;
            else                     state_d = S_PUBLISH;
          end else begin
            dclk_d = ph_nx[0];
            if (!ph_nx[0]) begin
              cmd_sh_d = {cmd_sh_q[6:0], 1'b0};
              din_d    = cmd_sh_q[6];
            end
            if (ph_nx[0] && ph_nx >= PH_SMP_LO && ph_nx <= PH_SMP_HI)
              raw_d = {raw_q[10:0], adc_dout};
          end
        end
      end

      S_PUBLISH: begin
        state_d = S_GAP_WAIT;
        cnt_d   = '0;
        if (pair_valid) begin
`ifdef TOUCH_AVG_EN
          if (avg_cnt_q == 2'd3) begin
            x_d         = sum_x_nx[13:6];
            y_d         = sum_y_nx[13:4];
            new_coord_d = 1'b1;
            tx_en_d     = 1'b1;
            stb_cnt_d   = STB_W'(STROBE_LEN);
            sum_x_d     = '0;
            sum_y_d     = '0;
            avg_cnt_d   = '0;
          end else begin
            sum_x_d   = sum_x_nx;
            sum_y_d   = sum_y_nx;
            avg_cnt_d = avg_cnt_q + 2'd1;
          end
`else
          x_d         = raw_x_q[11:4];
          y_d         = raw_q[11:2];
          new_coord_d = 1'b1;
          tx_en_d     = 1'b1;
          stb_cnt_d   = STB_W'(STROBE_LEN);
`endif
        end
      end

      S_GAP_WAIT: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d = '0;
          if (pen_down) start_x = 1'b1;
          else          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (pen_down) begin
          start_x = 1'b1;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tx_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Opening a frame: CS falls and DIN presents the command MSB before the first DCLK rise.
    if (start_x || start_y) begin
      state_d  = start_x ? S_CONV_X : S_CONV_Y;
      cnt_d    = '0;
      div_d    = '0;
      ph_d     = '0;
      cs_n_d   = 1'b0;
      dclk_d   = 1'b0;
      cmd_sh_d = start_x ? CMD_X : CMD_Y;
      din_d    = start_x ? CMD_X[7] : CMD_Y[7];
      raw_d    = '0;
    end
  end

  // Two-flop synchronizer for the asynchronous pen interrupt; resets to "pen up".
  always_ff @(posedge sys_clk or posedge iRST) begin
    if (iRST) begin
      pen_meta_q <= 1'b1;
      pen_sync_q <= 1'b1;
    end else begin
      pen_meta_q <= adc_penirq_n;
      pen_sync_q <= pen_meta_q;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
  always_ff @(posedge sys_clk or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      ph_q        <= '0;
      cmd_sh_q    <= '0;
      raw_q       <= '0;
      raw_x_q     <= '0;
      cs_n_q      <= 1'b1;
      dclk_q      <= 1'b0;
      din_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      new_coord_q <= 1'b0;
      tx_en_q     <= 1'b0;
      strobe_n_q  <= 1'b1;
      stb_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      ph_q        <= ph_d;
      cmd_sh_q    <= cmd_sh_d;
      raw_q       <= raw_d;
      raw_x_q     <= raw_x_d;
      cs_n_q      <= cs_n_d;
      dclk_q      <= dclk_d;
      din_q       <= din_d;
      x_q         <= x_d;
      y_q         <= y_d;
      new_coord_q <= new_coord_d;
      tx_en_q     <= tx_en_d;
      strobe_n_q  <= strobe_n_d;
      stb_cnt_q   <= stb_cnt_d;
    end
  end

`ifdef TOUCH_AVG_EN
  always_ff @(posedge sys_clk or posedge iRST) begin
    if (iRST) begin
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      avg_cnt_q <= '0;
    end else begin
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`endif

  assign adc_cs_n     = cs_n_q;
  assign adc_dclk     = dclk_q;
  assign adc_din      = din_q;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign new_coord    = new_coord_q;
  assign transmit_en  = tx_en_q;
  assign pen_strobe_n = strobe_n_q;

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Directed bench for touch_adc_ctrl with a behavioural AD7843 model on the SPI pins.
// Build with TOUCH_AVG_EN defined to run the averaging scenario instead of the direct-publish ones.
module tb_touch_adc_ctrl;

  localparam int CLK_DIV    = 2;
  localparam int DEBOUNCE   = 8;
  localparam int GAP        = 30;
  localparam int STROBE_LEN = 4;

  logic       sys_clk      = 1'b0;
  logic       iRST         = 1'b1;
  logic       adc_penirq_n = 1'b1;
  logic       adc_dout     = 1'b0;
  logic       adc_dclk, adc_din, adc_cs_n;
  logic [7:0] x_out;
  logic [9:0] y_out;
  logic       new_coord, transmit_en, pen_strobe_n;

  int checks   = 0;
  int failures = 0;

  touch_adc_ctrl #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .GAP(GAP), .STROBE_LEN(STROBE_LEN)
  ) dut (
    .sys_clk(sys_clk), .iRST(iRST), .adc_penirq_n(adc_penirq_n), .adc_dout(adc_dout),
    .adc_dclk(adc_dclk), .adc_din(adc_din), .adc_cs_n(adc_cs_n),
    .x_out(x_out), .y_out(y_out), .new_coord(new_coord),
    .transmit_en(transmit_en), .pen_strobe_n(pen_strobe_n)
  );

  always #5 sys_clk = ~sys_clk;

  // ADC model: captures the command on rises 1..8, shifts 12 result bits out after falls 9..20.
  logic [11:0] x_q[$];
  logic [11:0] y_val      = 12'h000;
  logic [11:0] cur        = 12'h000;
  logic [7:0]  cmd        = 8'h00;
  logic [7:0]  last_cmd_x = 8'h00;
  logic [7:0]  last_cmd_y = 8'h00;
  int          rises = 0, falls = 0, last_rises = 0;
  int          cs_falls = 0, x_frames = 0, coord_count = 0;
  bit          in_y = 1'b0;

  always @(negedge adc_cs_n) begin
    cs_falls++;
    rises = 0;
    falls = 0;
    cmd   = 8'h00;
    in_y  = 1'b0;
  end

  always @(posedge adc_cs_n) last_rises = rises;

  always @(posedge adc_dclk) if (!adc_cs_n) begin
    rises++;
    if (rises <= 8) cmd = {cmd[6:0], adc_din};
    if (rises == 8) begin
      if (cmd == 8'hD0) begin
        last_cmd_x = cmd;
        x_frames++;
        if (x_q.size() > 1) cur = x_q.pop_front();
        else                cur = x_q[0];
      end else begin
        last_cmd_y = cmd;
        cur  = y_val;
        in_y = 1'b1;
      end
    end
  end

  always @(negedge adc_dclk) if (!adc_cs_n) begin
    falls++;
    if (falls >= 9 && falls <= 20) adc_dout = cur[20 - falls];
    else                           adc_dout = 1'b0;
  end

  always @(posedge sys_clk) if (new_coord === 1'b1) coord_count++;

  task automatic wait_coord(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (new_coord === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (transmit_en === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    iRST = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (adc_cs_n !== 1'b1)      begin failures++; $display("FAIL rst_cs_n got=%b exp=1", adc_cs_n); end
    checks++; if (adc_dclk !== 1'b0)      begin failures++; $display("FAIL rst_dclk got=%b exp=0", adc_dclk); end
    checks++; if (adc_din !== 1'b0)       begin failures++; $display("FAIL rst_din got=%b exp=0", adc_din); end
    checks++; if (x_out !== 8'h00)        begin failures++; $display("FAIL rst_x_out got=%h exp=00", x_out); end
    checks++; if (y_out !== 10'h000)      begin failures++; $display("FAIL rst_y_out got=%h exp=000", y_out); end
    checks++; if (new_coord !== 1'b0)     begin failures++; $display("FAIL rst_new_coord got=%b exp=0", new_coord); end
    checks++; if (transmit_en !== 1'b0)   begin failures++; $display("FAIL rst_transmit_en got=%b exp=0", transmit_en); end
    checks++; if (pen_strobe_n !== 1'b1)  begin failures++; $display("FAIL rst_strobe got=%b exp=1", pen_strobe_n); end
    iRST = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_basic;
    bit   ok;
    logic prev_te;
    x_q.delete(); x_q.push_back(12'hA5C);
    y_val = 12'h3F0;
    adc_penirq_n = 1'b0;
    ok = 1'b0;
    prev_te = transmit_en;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (new_coord === 1'b1) begin ok = 1'b1; break; end
      prev_te = transmit_en;
    end
    checks++; if (!ok)                    begin failures++; $display("FAIL basic_timeout got=no_coord exp=coord"); end
    checks++; if (x_out !== 8'hA5)        begin failures++; $display("FAIL basic_x_out got=%h exp=a5", x_out); end
    checks++; if (y_out !== 10'h0FC)      begin failures++; $display("FAIL basic_y_out got=%h exp=0fc", y_out); end
    checks++; if (transmit_en !== 1'b1)   begin failures++; $display("FAIL basic_te_rise got=%b exp=1", transmit_en); end
    checks++; if (prev_te !== 1'b0)       begin failures++; $display("FAIL basic_te_before got=%b exp=0", prev_te); end
    checks++; if (last_cmd_x !== 8'hD0)   begin failures++; $display("FAIL basic_cmd_x got=%h exp=d0", last_cmd_x); end
    checks++; if (last_cmd_y !== 8'h90)   begin failures++; $display("FAIL basic_cmd_y got=%h exp=90", last_cmd_y); end
    checks++; if (last_rises != 24)       begin failures++; $display("FAIL basic_dclk_count got=%0d exp=24", last_rises); end
    for (int i = 1; i <= STROBE_LEN; i++) begin
      @(negedge sys_clk);
      checks++; if (pen_strobe_n !== 1'b0) begin failures++; $display("FAIL basic_strobe_low%0d got=%b exp=0", i, pen_strobe_n); end
      if (i == 1) begin
        checks++; if (new_coord !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", new_coord); end
      end
    end
    @(negedge sys_clk);
    checks++; if (pen_strobe_n !== 1'b1)  begin failures++; $display("FAIL basic_strobe_end got=%b exp=1", pen_strobe_n); end
    adc_penirq_n = 1'b1;
    wait_release(3000, ok);
    checks++; if (!ok)                    begin failures++; $display("FAIL basic_release got=te_high exp=te_low"); end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_glitch;
    int base_falls, base_coord;
    base_falls = cs_falls;
    base_coord = coord_count;
    adc_penirq_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    adc_penirq_n = 1'b1;
    repeat (100) @(negedge sys_clk);
    checks++; if (cs_falls != base_falls)   begin failures++; $display("FAIL glitch_cs got=%0d exp=%0d", cs_falls, base_falls); end
    checks++; if (transmit_en !== 1'b0)     begin failures++; $display("FAIL glitch_te got=%b exp=0", transmit_en); end
    checks++; if (coord_count != base_coord) begin failures++; $display("FAIL glitch_coord got=%0d exp=%0d", coord_count, base_coord); end
  endtask

  task automatic test_invalid;
    bit ok;
    int base_x, base_coord;
    x_q.delete(); x_q.push_back(12'hFFF); x_q.push_back(12'h123);
    y_val = 12'h456;
    base_x = x_frames;
    base_coord = coord_count;
    adc_penirq_n = 1'b0;
    wait_coord(3000, ok);
    checks++; if (!ok)                        begin failures++; $display("FAIL inv_timeout got=no_coord exp=coord"); end
    checks++; if (x_frames - base_x != 2)     begin failures++; $display("FAIL inv_x_frames got=%0d exp=2", x_frames - base_x); end
    checks++; if (coord_count != base_coord)  begin failures++; $display("FAIL inv_early_publish got=%0d exp=%0d", coord_count, base_coord); end
    checks++; if (x_out !== 8'h12)            begin failures++; $display("FAIL inv_x_out got=%h exp=12", x_out); end
    checks++; if (y_out !== 10'h115)          begin failures++; $display("FAIL inv_y_out got=%h exp=115", y_out); end
    adc_penirq_n = 1'b1;
    wait_release(3000, ok);
    checks++; if (!ok)                        begin failures++; $display("FAIL inv_release got=te_high exp=te_low"); end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_release_mid_frame;
    bit ok;
    int base_falls, n;
    x_q.delete(); x_q.push_back(12'h200);
    y_val = 12'h300;
    adc_penirq_n = 1'b0;
    wait_coord(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_first_timeout got=no_coord exp=coord"); end
    base_falls = cs_falls;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (cs_falls != base_falls) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL mid_frame_start got=no_cs exp=cs_fall"); end
    repeat (20) @(negedge sys_clk);
    adc_penirq_n = 1'b1;
    wait_coord(500, ok);
    checks++; if (!ok)                    begin failures++; $display("FAIL mid_publish got=no_coord exp=coord"); end
    checks++; if (last_rises != 24)       begin failures++; $display("FAIL mid_frame_len got=%0d exp=24", last_rises); end
    checks++; if (x_out !== 8'h20)        begin failures++; $display("FAIL mid_x_out got=%h exp=20", x_out); end
    checks++; if (y_out !== 10'h0C0)      begin failures++; $display("FAIL mid_y_out got=%h exp=0c0", y_out); end
    n = 0;
    while (transmit_en === 1'b1 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checks++; if (n != GAP + DEBOUNCE)    begin failures++; $display("FAIL mid_release_delay got=%0d exp=%0d", n, GAP + DEBOUNCE); end
    checks++; if (x_out !== 8'h20)        begin failures++; $display("FAIL mid_x_hold got=%h exp=20", x_out); end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_average;
    bit ok;
    int base_x, base_coord;
    x_q.delete();
    x_q.push_back(12'd100); x_q.push_back(12'd104); x_q.push_back(12'd108); x_q.push_back(12'd112);
    y_val = 12'h400;
    base_x = x_frames;
    base_coord = coord_count;
    adc_penirq_n = 1'b0;
    wait_coord(5000, ok);
    checks++; if (!ok)                        begin failures++; $display("FAIL avg_timeout got=no_coord exp=coord"); end
    checks++; if (x_frames - base_x != 4)     begin failures++; $display("FAIL avg_pairs got=%0d exp=4", x_frames - base_x); end
    checks++; if (coord_count != base_coord)  begin failures++; $display("FAIL avg_early_publish got=%0d exp=%0d", coord_count, base_coord); end
    checks++; if (x_out !== 8'h06)            begin failures++; $display("FAIL avg_x_out got=%h exp=06", x_out); end
    checks++; if (y_out !== 10'h100)          begin failures++; $display("FAIL avg_y_out got=%h exp=100", y_out); end
    adc_penirq_n = 1'b1;
    wait_release(3000, ok);
    checks++; if (!ok)                        begin failures++; $display("FAIL avg_release got=te_high exp=te_low"); end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int base_falls;
    x_q.delete(); x_q.push_back(12'h555);
    y_val = 12'h666;
    adc_penirq_n = 1'b0;
    wait_coord(5000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_publish got=no_coord exp=coord"); end
    base_falls = cs_falls;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (cs_falls != base_falls && in_y) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rmid_y_frame got=none exp=y_frame"); end
    repeat (5) @(negedge sys_clk);
    checks++; if (adc_cs_n !== 1'b0)     begin failures++; $display("FAIL rmid_in_frame got=%b exp=0", adc_cs_n); end
    iRST = 1'b1;
    #1;
    checks++; if (adc_cs_n !== 1'b1)     begin failures++; $display("FAIL rmid_cs_n got=%b exp=1", adc_cs_n); end
    checks++; if (adc_dclk !== 1'b0)     begin failures++; $display("FAIL rmid_dclk got=%b exp=0", adc_dclk); end
    checks++; if (adc_din !== 1'b0)      begin failures++; $display("FAIL rmid_din got=%b exp=0", adc_din); end
    checks++; if (x_out !== 8'h00)       begin failures++; $display("FAIL rmid_x_out got=%h exp=00", x_out); end
    checks++; if (y_out !== 10'h000)     begin failures++; $display("FAIL rmid_y_out got=%h exp=000", y_out); end
    checks++; if (new_coord !== 1'b0)    begin failures++; $display("FAIL rmid_new_coord got=%b exp=0", new_coord); end
    checks++; if (transmit_en !== 1'b0)  begin failures++; $display("FAIL rmid_te got=%b exp=0", transmit_en); end
    checks++; if (pen_strobe_n !== 1'b1) begin failures++; $display("FAIL rmid_strobe got=%b exp=1", pen_strobe_n); end
    adc_penirq_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    iRST = 1'b0;
    repeat (50) @(negedge sys_clk);
    checks++; if (adc_cs_n !== 1'b1)     begin failures++; $display("FAIL rmid_idle_cs got=%b exp=1", adc_cs_n); end
  endtask

  initial begin
    test_reset;
    test_glitch;
`ifdef TOUCH_AVG_EN
    test_average;
`else
    test_basic;
    test_invalid;
    test_release_mid_frame;
`endif
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
